// File: rtl/inc_result_stage.sv
// inc_result_stage: registered output stage behind the dual-operand incrementer.
// Accepts results through a valid/ready handshake. Derives the zero and negative
// flags when a result is accepted. Buffers up to two results in a two-entry skid
// FIFO, so back-pressure from the consumer never drops a result.
// Optional build macro INC_RESULT_STAGE_STICKY_FLAGS_EN adds sticky carry and
// overflow status registers, plus a flag_clr input.
module inc_result_stage #(
  parameter int B_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B_W-1:0] in_y,
  input  logic           in_cout,
  input  logic           in_v,
  input  logic           in_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [B_W-1:0] out_y,
  output logic           out_c,
  output logic           out_v,
  output logic           out_z,
  output logic           out_n,
`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
  output logic           sticky_c,
  output logic           sticky_v,
  input  logic           flag_clr,
`endif
  output logic           out_sel
);

  typedef struct packed {
    logic [B_W-1:0] y;
    logic           c;
    logic           v;
    logic           z;
    logic           n;
    logic           sel;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     last_q;
  entry_t     push_entry;
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       push, pop;

  // Ready and valid depend only on the stored count, never on the current inputs
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Build the entry to store, computing the zero and negative flags at push time
  always_comb begin
    push_entry.y   = in_y;
    push_entry.c   = in_cout;
    push_entry.v   = in_v;
    push_entry.z   = (in_y == '0);
    push_entry.n   = in_y[B_W-1];
    push_entry.sel = in_sel;
  end

  // Compute the next count and pointers. The pointers are 1 bit wide, so they wrap from 1 to 0.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Register the count and the pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Update FIFO storage and remember the most recently popped entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      last_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
      if (pop)  last_q <= mem_q[rd_ptr_q];
    end
  end

  // While the FIFO is empty, present the last popped entry. Otherwise present the head entry.
  // When the FIFO empties, the read pointer moves to a slot that may hold an older result.
  always_comb begin
    head = (count_q == 2'd0) ? last_q : mem_q[rd_ptr_q];
  end

  assign out_y   = head.y;
  assign out_c   = head.c;
  assign out_v   = head.v;
  assign out_z   = head.z;
  assign out_n   = head.n;
  assign out_sel = head.sel;

`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
  logic sticky_c_q, sticky_c_d;
  logic sticky_v_q, sticky_v_d;

  // Clear first, then OR in the pushed flags, so an event pushed in the same cycle as a clear survives
  always_comb begin
    sticky_c_d = flag_clr ? 1'b0 : sticky_c_q;
    sticky_v_d = flag_clr ? 1'b0 : sticky_v_q;
    if (push) begin
      sticky_c_d = sticky_c_d | in_cout;
      sticky_v_d = sticky_v_d | in_v;
    end
  end

  // Register the sticky status bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
    end else begin
      sticky_c_q <= sticky_c_d;
      sticky_v_q <= sticky_v_d;
    end
  end

  assign sticky_c = sticky_c_q;
  assign sticky_v = sticky_v_q;
`endif

endmodule

// File: tb/tb_inc_result_stage.sv
// Directed testbench for inc_result_stage (B_W = 4), with hand-computed expected values.
// The sticky-flag checks run only when INC_RESULT_STAGE_STICKY_FLAGS_EN is defined.
module tb_inc_result_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_y;
  logic       in_cout;
  logic       in_v;
  logic       in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic       out_c;
  logic       out_v;
  logic       out_z;
  logic       out_n;
  logic       out_sel;
`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
  logic       sticky_c;
  logic       sticky_v;
  logic       flag_clr;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inc_result_stage #(.B_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_cout   (in_cout),
    .in_v      (in_v),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .out_n     (out_n),
`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
    .sticky_c  (sticky_c),
    .sticky_v  (sticky_v),
    .flag_clr  (flag_clr),
`endif
    .out_sel   (out_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] y, input logic c, input logic ov, input logic s);
    in_valid = v;
    in_y     = y;
    in_cout  = c;
    in_v     = ov;
    in_sel   = s;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_y", out_y, 0);
    rst_n = 1'b1;
    tick();

    // Accept one result, then assert reset mid-stream
    drive(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_y", out_y, 0);
    check_eq("mid_rst_out_c", out_c, 0);
`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
    check_eq("mid_rst_sticky_v", sticky_v, 0);
`endif
    #1 rst_n = 1'b1;
    tick();

    // Single transfer: the incremented 4'hF wrapped to 0 with a carry out
    out_ready = 1'b1;
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("single_valid", out_valid, 1);
    check_eq("single_y", out_y, 0);
    check_eq("single_c", out_c, 1);
    check_eq("single_v", out_v, 0);
    check_eq("single_z", out_z, 1);
    check_eq("single_n", out_n, 0);
    check_eq("single_sel", out_sel, 1);
    tick();
    check_eq("single_popped", out_valid, 0);
    check_eq("hold_last_c", out_c, 1);
    check_eq("hold_last_sel", out_sel, 1);

    // Back-pressure fill
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bp_ready1", in_ready, 1);
    check_eq("bp_head1", out_y, 3);
    drive(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bp_full_ready", in_ready, 0);
    check_eq("bp_hold_y", out_y, 3);
    drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("bp_refused_ready", in_ready, 0);
    check_eq("bp_hold_y2", out_y, 3);
    check_eq("bp_hold_n", out_n, 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_pop2_y", out_y, 8);
    check_eq("bp_pop2_n", out_n, 1);
    check_eq("bp_ready_back", in_ready, 1);
    tick();
    check_eq("bp_drained", out_valid, 0);

    // Streaming with out_ready held high
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, i[3:0], 1'b0, 1'b0, 1'b0);
      tick();
      check_eq($sformatf("stream_valid_%0d", i), out_valid, 1);
      check_eq($sformatf("stream_y_%0d", i), out_y, i);
      check_eq($sformatf("stream_ready_%0d", i), in_ready, 1);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("stream_end", out_valid, 0);

    // Simultaneous push and pop at count 1
    out_ready = 1'b0;
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("pp_head2", out_y, 2);
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_eq("pp_head5", out_y, 5);
    check_eq("pp_valid", out_valid, 1);
    check_eq("pp_ready", in_ready, 1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    tick();
    check_eq("pp_still_one", out_valid, 1);
    check_eq("pp_still_5", out_y, 5);
    out_ready = 1'b1;
    tick();
    check_eq("pp_empty", out_valid, 0);

    // Asynchronous reset while the FIFO is full
    out_ready = 1'b0;
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("full_before_rst", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    tick();
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_y", out_y, 6);
    check_eq("post_rst_alone", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check_eq("post_rst_single", out_valid, 0);

`ifdef INC_RESULT_STAGE_STICKY_FLAGS_EN
    // Sticky status flags
    drive(1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sticky_v_set", sticky_v, 1);
    check_eq("sticky_c_0a", sticky_c, 0);
    tick();
    flag_clr = 1'b1;
    tick();
    check_eq("sticky_v_clr", sticky_v, 0);
    drive(1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
    tick();
    flag_clr = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sticky_v_wins", sticky_v, 1);
    check_eq("sticky_c_0b", sticky_c, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
